apb_slave_regfile: RTL

- APB completer (slave) that answers transfers issued by the team's APB requester.
- Holds a small bank of memory-mapped 32-bit registers.
- Inserts a programmable number of wait states and flags errors on pslverr.
- Sits behind one psel_x bit of the APB fabric. Serves as the RTL DUT for the UVC slave agent and as a reusable peripheral register block.

---
 rtl/apb_slv_pkg.sv | 14 +
 rtl/apb_slv_regbank.sv | 54 +++++
 rtl/apb_slave_regfile.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slv_pkg;

  typedef enum logic [0:0] {IDLE, ACCESS} apb_slv_state_e;

  localparam logic [31:0]  ID_VALUE_DEFAULT = 32'hA5B0_0001;
  localparam int unsigned  WAIT_STATES_MAX  = 15;

  // Word index of a byte address.
  function automatic int unsigned addr_to_idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// Word register array with byte-lane write enables; register 0 is a read-only constant.
module apb_slv_regbank #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           IDX_W       = 6,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];

  always_ff @(posedge pclock) begin
    if (preset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wbe[b]) begin
              regs_q[i][b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Out-of-range indices read as zero; the caller flags them as errors anyway.
  always_comb begin
    rd_data = '0;
    if (rd_idx == '0) begin
      rd_data = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register bank, programmable wait states and error decode.
// Optional byte strobes (pstrb port) are enabled by defining APB_SLV_PSTRB_EN.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = ID_VALUE_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  apb_slv_state_e        state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic                  resp_en;
  logic                  complete;
  logic                  wr_en;
  logic                  err_d;
  int unsigned           idx_d;
  logic [STRB_W-1:0]     strb_in;
  logic [DATA_WIDTH-1:0] rd_data;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in = pstrb;
`else
  assign strb_in = '1;
`endif

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    resp_en  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          wcnt_d  = WAIT_INIT;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = strb_in;
          resp_en = (WAIT_INIT == 4'd0);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pready_q) begin
          if (penable) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            resp_en = 1'b1;
          end
        end else begin
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end
          resp_en = (wcnt_d == 4'd0);
        end
      end
    endcase
  end

  // Decode follows the next captured address, so a zero-wait response is ready at setup.
  assign idx_d = addr_to_idx(32'(addr_d));
  assign err_d = (addr_d[1:0] != 2'b00) || (idx_d >= NUM_REGS) || (write_d && idx_d == 0);
  assign wr_en = complete && write_q && !err_d;

  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (resp_en) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!err_d && !write_d) begin
        prdata_d = rd_data;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  apb_slv_regbank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .ID_VALUE    (ID_VALUE),
    .RESET_VALUE (RESET_VALUE)
  ) u_regbank (
    .pclock  (pclock),
    .preset  (preset),
    .wr_en   (wr_en),
    .wr_idx  (addr_q[ADDR_WIDTH-1:2]),
    .wdata   (wdata_q),
    .wbe     (strb_q),
    .rd_idx  (addr_d[ADDR_WIDTH-1:2]),
    .rd_data (rd_data)
  );

endmodule
